// File: rtl/vel_pingpong_cache_pkg.sv
// Shared widths and FSM state type for the MU-stage velocity cache.
package MD_pkg;

  localparam int FLOAT_STRUCT_WIDTH = 96;
  localparam int PARTICLE_ID_WIDTH  = 8;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_UPDATE = 2'd1,
    VC_SWAP   = 2'd2
  } vel_cache_state_t;

endpackage

// File: rtl/vel_pingpong_cache_bank.sv
// One velocity bank: synchronous-write simple dual-port RAM with a
// registered read followed by an output register (2-cycle read latency).
module vel_cache_bank
  import MD_pkg::*;
#(
  parameter int DATA_WIDTH = FLOAT_STRUCT_WIDTH,
  parameter int DEPTH      = 2 ** PARTICLE_ID_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_stage_q;
  logic [DATA_WIDTH-1:0] rd_out_q;

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_stage_q <= mem_q[rd_addr_i];
    end
    rd_out_q <= rd_stage_q;
  end

  assign rd_data_o = rd_out_q;

endmodule

// File: rtl/vel_pingpong_cache.sv
// Double-buffered velocity cache: one bank serves MU reads while the other
// collects the updated velocities; the roles swap when a pass ends.
module vel_pingpong_cache
  import MD_pkg::*;
#(
  parameter int DATA_WIDTH = FLOAT_STRUCT_WIDTH,
  parameter int DEPTH      = 2 ** PARTICLE_ID_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_init_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_init_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_init_wr_vel,
  input  logic                  i_MU_start,
  input  logic                  i_MU_working,
  input  logic                  i_MU_wr_en,
  input  logic [DATA_WIDTH-1:0] i_MU_wr_vel,
  input  logic                  i_MU_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_MU_rd_addr,
  output logic [DATA_WIDTH-1:0] o_MU_vel,
  output logic                  o_MU_vel_valid,
  output logic                  o_MU_vel_oob,
  output logic [ADDR_WIDTH-1:0] o_active_count,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic                  o_swap_done
);

  // The write pointer must be able to hold DEPTH itself to mark a full bank.
  localparam int                   PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] PTR_FIRST = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_FULL  = PTR_WIDTH'(DEPTH);

  vel_cache_state_t      state_q, state_d;
  logic                  phase_q, phase_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  init_we;
  logic                  shadow_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  swap_done;

  logic                  bank0_we, bank1_we;
  logic [DATA_WIDTH-1:0] bank0_rdata, bank1_rdata;

  logic                  rd_oob;
  logic                  rd_vld1_q, rd_sel1_q, rd_oob1_q;
  logic                  rd_vld2_q, rd_sel2_q, rd_oob2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VC_IDLE;
      phase_q    <= 1'b0;
      wr_ptr_q   <= PTR_FIRST;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    init_we    = 1'b0;
    shadow_we  = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    busy       = 1'b0;
    swap_done  = 1'b0;

    unique case (state_q)
      VC_IDLE: begin
        if (i_init_wr_en && (i_init_wr_addr != '0)) begin
          init_we = 1'b1;
          wr_addr = i_init_wr_addr;
          wr_data = i_init_wr_vel;
          if (i_init_wr_addr > count_q) begin
            count_d = i_init_wr_addr;
          end
        end
        if (i_MU_start) begin
          state_d    = VC_UPDATE;
          overflow_d = 1'b0;
        end
      end

      VC_UPDATE: begin
        busy = 1'b1;
        if (i_MU_wr_en) begin
          if (wr_ptr_q < PTR_FULL) begin
            shadow_we = 1'b1;
            wr_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
            wr_data   = i_MU_wr_vel;
            wr_ptr_d  = wr_ptr_q + PTR_FIRST;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!i_MU_working) begin
          state_d = VC_SWAP;
        end
      end

      VC_SWAP: begin
        busy      = 1'b1;
        swap_done = 1'b1;
        phase_d   = ~phase_q;
        count_d   = ADDR_WIDTH'(wr_ptr_q - PTR_FIRST);
        wr_ptr_d  = PTR_FIRST;
        state_d   = VC_IDLE;
      end

      default: begin
        state_d = VC_IDLE;
      end
    endcase
  end

  // Initial loads target the active bank, MU updates the shadow bank.
  assign bank0_we = (init_we & ~phase_q) | (shadow_we & phase_q);
  assign bank1_we = (init_we & phase_q) | (shadow_we & ~phase_q);

  vel_cache_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk       (clk),
    .wr_en_i   (bank0_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (i_MU_rd_en & ~phase_q),
    .rd_addr_i (i_MU_rd_addr),
    .rd_data_o (bank0_rdata)
  );

  vel_cache_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk       (clk),
    .wr_en_i   (bank1_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (i_MU_rd_en & phase_q),
    .rd_addr_i (i_MU_rd_addr),
    .rd_data_o (bank1_rdata)
  );

  // Bank select and range check travel with the address, so a read issued
  // in the swap cycle still resolves against the pre-swap active bank.
  assign rd_oob = (i_MU_rd_addr == '0) || (i_MU_rd_addr > count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld1_q <= 1'b0;
      rd_sel1_q <= 1'b0;
      rd_oob1_q <= 1'b0;
      rd_vld2_q <= 1'b0;
      rd_sel2_q <= 1'b0;
      rd_oob2_q <= 1'b0;
    end else begin
      rd_vld1_q <= i_MU_rd_en;
      rd_sel1_q <= phase_q;
      rd_oob1_q <= rd_oob;
      rd_vld2_q <= rd_vld1_q;
      rd_sel2_q <= rd_sel1_q;
      rd_oob2_q <= rd_oob1_q;
    end
  end

  assign o_MU_vel       = (rd_vld2_q && !rd_oob2_q) ?
                          (rd_sel2_q ? bank1_rdata : bank0_rdata) : '0;
  assign o_MU_vel_valid = rd_vld2_q;
  assign o_MU_vel_oob   = rd_vld2_q & rd_oob2_q;
  assign o_active_count = count_q;
  assign o_overflow     = overflow_q;
  assign o_busy         = busy;
  assign o_swap_done    = swap_done;

endmodule
